dram_stream_ctrl: RTL and testbench

- Parametrised successor to the processor data RAM.
- Replaces file-based image load/dump with streaming handshakes.
- A four-state controller sequences image load, processor run and result dump.
- Sits between the image I/O interface and the downsampling processor's data port.

---
 rtl/dram_stream_ctrl.sv | 136 +++++++++++++
 tb/tb_dram_stream_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_stream_ctrl.sv
// dram_stream_ctrl: single-port data RAM for the downsampling processor with
// streaming image load and result dump, sequenced by a four-state controller.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   load_start, dump_start      transfer requests, honoured in IDLE and RUN
//   ld_valid/ld_data/ld_ready   load stream in; rd_done pulses when complete
//   addr/din/write/read         processor port, active in RUN only
//   dout/dout_valid             processor read data, latency 1
//   dp_valid/dp_data/dp_ready   dump stream out; wr_done pulses when complete
//   busy                        high while loading or dumping
module dram_stream_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int LOAD_LEN  = 65536,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              rd_done,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              write,
  input  logic              read,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dump_start,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_data,
  input  logic              dp_ready,
  output logic              wr_done,
  output logic              busy
);
  // counters must reach 2**ADDR_W, hence one extra bit
  localparam int CW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP} state_t;

  state_t            state;
  logic [CW-1:0]     ld_cnt;
  logic [CW-1:0]     dp_cnt;   // words already moved into the dump output register
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ld_fire, ld_last, pr_wr, dp_more;
  logic [ADDR_W-1:0] dp_addr;

  assign ld_fire = (state == S_LOAD) && ld_valid && ld_ready;
  assign ld_last = ld_cnt == CW'(LOAD_LEN - 1);
  assign pr_wr   = (state == S_RUN) && write;
  assign dp_more = dp_cnt != CW'(DUMP_LEN);
  // truncation gives the wrap past the top of the RAM
  assign dp_addr = ADDR_W'(DUMP_BASE) + dp_cnt[ADDR_W-1:0];

  // RAM has no reset: contents survive rst_n. Reads elsewhere see the
  // pre-write value in the same cycle, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (ld_fire)    mem[ld_cnt[ADDR_W-1:0]] <= ld_data;
    else if (pr_wr) mem[addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ld_cnt     <= '0;
      dp_cnt     <= '0;
      ld_ready   <= 1'b0;
      rd_done    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dp_valid   <= 1'b0;
      dp_data    <= '0;
      wr_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rd_done    <= 1'b0;
      wr_done    <= 1'b0;
      dout_valid <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (state == S_RUN && read) begin
            dout       <= mem[addr];
            dout_valid <= 1'b1;
          end
          if (load_start) begin
            state    <= S_LOAD;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            ld_cnt   <= '0;
          end else if (dump_start) begin
            state    <= S_DUMP;
            busy     <= 1'b1;
            dp_cnt   <= '0;
            dp_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_fire) begin
            if (ld_last) begin
              state    <= S_RUN;
              ld_cnt   <= '0;
              ld_ready <= 1'b0;
              rd_done  <= 1'b1;
              busy     <= 1'b0;
            end else begin
              ld_cnt <= ld_cnt + CW'(1);
            end
          end
        end
        S_DUMP: begin
          // output register is free when empty or being drained this cycle
          if (!dp_valid || dp_ready) begin
            if (dp_more) begin
              dp_data  <= mem[dp_addr];
              dp_valid <= 1'b1;
              dp_cnt   <= dp_cnt + CW'(1);
            end else if (dp_valid) begin
              // final word handed off
              state    <= S_IDLE;
              dp_valid <= 1'b0;
              dp_cnt   <= '0;
              wr_done  <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_stream_ctrl.sv
// Bench for dram_stream_ctrl with a small geometry (16 x 8-bit RAM, load of 16,
// dump of 4 from address 14). A plain array mirrors RAM contents; dump words
// and processor reads are predicted from it.
module tb_dram_stream_ctrl;
  localparam int DW = 8, AW = 4, LL = 16, DB = 14, DL = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          load_start, ld_valid, ld_ready, rd_done;
  logic [DW-1:0] ld_data, din, dout, dp_data;
  logic [AW-1:0] addr;
  logic          write, read, dout_valid, dump_start, dp_valid, dp_ready, wr_done, busy;

  always #5 clk = ~clk;

  dram_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LOAD_LEN(LL), .DUMP_BASE(DB), .DUMP_LEN(DL)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .rd_done(rd_done), .addr(addr), .din(din), .write(write), .read(read),
    .dout(dout), .dout_valid(dout_valid), .dump_start(dump_start), .dp_valid(dp_valid),
    .dp_data(dp_data), .dp_ready(dp_ready), .wr_done(wr_done), .busy(busy));

  int            nvec = 0, nerr = 0;
  logic [DW-1:0] mdl [16];
  logic [DW-1:0] m_dout;
  logic [DW-1:0] ex [4];

  typedef struct {
    logic          wr, rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] eo;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    load_start = 0; dump_start = 0; ld_valid = 0; ld_data = 0; addr = 0;
    din = 0; write = 0; read = 0; dp_ready = 0;
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_flags"}, {26'd0, ld_ready, rd_done, dout_valid, dp_valid, wr_done, busy}, 0);
    chk({nm, "_dout"}, dout, 0);
    chk({nm, "_dp_data"}, dp_data, 0);
  endtask

  task automatic model_dump_exp();
    for (int k = 0; k < DL; k++) ex[k] = mdl[(DB + k) % 16];
  endtask

  // n words streamed; n < LL leaves the load unfinished for the abort test
  task automatic do_load(input int n, input bit both, input bit stall, input bit seq);
    int i = 0, cyc = 0;
    logic v;
    logic [DW-1:0] d;
    load_start = 1; dump_start = both;
    tick();
    load_start = 0; dump_start = 0;
    chk("load_entry_ld_ready", ld_ready, 1);
    chk("load_entry_busy", busy, 1);
    while (i < n && cyc < 400) begin
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      d = seq ? 8'(i) : 8'($urandom);
      chk("ld_ready_hi", ld_ready, 1);
      ld_valid = v; ld_data = d;
      write = 1; read = 1; addr = 4'($urandom); din = 8'($urandom);
      dump_start = 1'($urandom);
      if (v) begin mdl[i] = d; i++; end
      tick(); cyc++;
      chk("ld_dout_valid", dout_valid, 0);
      chk("rd_done", rd_done, (i == LL) ? 1 : 0);
    end
    clr();
    chk("load_word_count", i, n);
    if (n == LL) begin
      chk("ld_ready_after", ld_ready, 0);
      chk("busy_after_load", busy, 0);
      tick();
      chk("rd_done_once", rd_done, 0);
      chk("ld_ready_stays_low", ld_ready, 0);
    end
  endtask

  // mode 0: ready always; 1: ready 0,0,1,0,1,...; 2: random ready
  task automatic do_dump(input int mode, input logic [DW-1:0] e [4]);
    int got = 0, cyc = 0, first = -1, wrd = 0;
    bit r, stall = 0;
    logic [DW-1:0] pd = 0;
    dump_start = 1;
    tick();
    dump_start = 0;
    chk("dump_entry_busy", busy, 1);
    chk("dump_entry_ld_ready", ld_ready, 0);
    while (got < DL && cyc < 60) begin
      case (mode)
        0: r = 1'b1;
        1: r = (cyc < 2) ? 1'b0 : ((cyc % 2) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (stall) begin
        chk("dp_hold_valid", dp_valid, 1);
        chk("dp_hold_data", dp_data, pd);
      end
      if (dp_valid && first < 0) first = cyc;
      if (dp_valid && r) begin
        chk("dp_word", dp_data, e[got]);
        got++;
      end
      stall = dp_valid && !r;
      pd = dp_data;
      if (wr_done) wrd++;
      dp_ready = r; write = 1; read = 1; addr = 4'($urandom); din = 8'($urandom);
      tick(); cyc++;
      chk("dump_dout_valid", dout_valid, 0);
    end
    clr();
    chk("dump_word_count", got, DL);
    chk("first_valid_latency", (first >= 0 && first <= 2), 1);
    chk("early_wr_done", wrd, 0);
    chk("wr_done_pulse", wr_done, 1);
    chk("dp_valid_after", dp_valid, 0);
    chk("busy_after_dump", busy, 0);
    read = 1;
    tick();
    read = 0;
    chk("wr_done_once", wr_done, 0);
    chk("idle_read_ignored", dout_valid, 0);
  endtask

  initial begin
    bit w, r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    tbl[0] = '{1'b1, 1'b0, 4'd3,  8'hA5, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 4'd3,  8'h00, 1'b1, 8'hA5};
    tbl[2] = '{1'b0, 1'b0, 4'd3,  8'h00, 1'b0, 8'hA5};
    tbl[3] = '{1'b1, 1'b1, 4'd4,  8'h55, 1'b1, 8'h04};
    tbl[4] = '{1'b0, 1'b1, 4'd4,  8'h00, 1'b1, 8'h55};
    tbl[5] = '{1'b0, 1'b1, 4'd9,  8'h00, 1'b1, 8'h09};
    tbl[6] = '{1'b0, 1'b1, 4'd15, 8'h00, 1'b1, 8'h0F};
    tbl[7] = '{1'b1, 1'b1, 4'd5,  8'hC3, 1'b1, 8'h05};
    tbl[8] = '{1'b0, 1'b1, 4'd5,  8'h00, 1'b1, 8'hC3};

    clr();
    #12;
    chk_zero_outs("reset");
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    chk_zero_outs("post_reset");

    // load 0x00..0x0F, both starts together -> load wins
    do_load(LL, 1'b1, 1'b0, 1'b1);

    // processor access in RUN
    for (int k = 0; k < 9; k++) begin
      write = tbl[k].wr; read = tbl[k].rd; addr = tbl[k].a; din = tbl[k].d;
      tick();
      chk($sformatf("tbl%0d_dout_valid", k), dout_valid, tbl[k].ev);
      chk($sformatf("tbl%0d_dout", k), dout, tbl[k].eo);
      if (tbl[k].wr) mdl[tbl[k].a] = tbl[k].d;
      m_dout = tbl[k].eo;
    end
    clr();

    // dump wrap from address 14
    ex = '{8'h0E, 8'h0F, 8'h00, 8'h01};
    do_dump(0, ex);

    // random reload with stalls, then random processor traffic
    do_load(LL, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      a = 4'($urandom); d = 8'($urandom);
      write = w; read = r; addr = a; din = d;
      if (r) m_dout = mdl[a];
      if (w) mdl[a] = d;
      tick();
      chk("rand_dout_valid", dout_valid, r);
      chk("rand_dout", dout, m_dout);
    end
    clr();

    // backpressure from RUN, then random ready from IDLE
    model_dump_exp();
    do_dump(1, ex);
    do_dump(2, ex);

    // reset abort after 5 words of new data
    do_load(5, 1'b0, 1'b1, 1'b0);
    rst_n = 0;
    #2;
    chk_zero_outs("abort");
    tick();
    rst_n = 1;
    tick();
    chk("abort_no_rd_done", rd_done, 0);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_ld_ready", ld_ready, 0);
    model_dump_exp();
    do_dump(0, ex);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
